// File: rtl/dm_cache_if.sv
// dm_cache_if: CPU-side and memory-side bus of the direct-mapped cache controller.
//   slave  : the controller view (takes CPU requests, issues memory accesses)
//   master : the environment view (CPU + backing memory)
//   cpu_req/we/addr/wdata -> ; cpu_ready/done/hit/rdata <- ; flush ->
//   mem_req/we/addr/wdata <- ; mem_ack/rdata ->
interface dm_cache_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_done;
  logic              cpu_hit;
  logic [DATA_W-1:0] cpu_rdata;
  logic              flush;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_ack, mem_rdata,
    output cpu_ready, cpu_done, cpu_hit, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_ack, mem_rdata,
    input  cpu_ready, cpu_done, cpu_hit, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: sequencing controller for a direct-mapped, one-word-per-line cache.
//   Read miss fetches from memory and fills; writes are write-through, no-allocate.
//   A flush invalidates every line, one line per cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - dm_cache_if.slave: CPU request/response and memory request/ack signals
module dm_cache_ctrl #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 10
) (
  input  logic     clk,
  input  logic     rst,
  dm_cache_if.slave bus
);
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                whit_q, whit_d;       // write hit, reported when the memory write acks
  logic                flush_pend_q, flush_pend_d;
  logic [INDEX_W-1:0]  fcnt_q, fcnt_d;
  logic                done_q, done_d;
  logic                hit_q, hit_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [LINES-1:0]    valid_q;

  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [DATA_W-1:0]   data_mem [LINES];

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    atag;
  logic                hit;
  logic                dwe, fill, clr;
  logic [DATA_W-1:0]   dwdata;

  assign idx  = addr_q[INDEX_W+1:2];
  assign atag = addr_q[ADDR_W-1:INDEX_W+2];
  assign hit  = valid_q[idx] && (tag_mem[idx] == atag);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    whit_d       = whit_q;
    flush_pend_d = flush_pend_q;
    fcnt_d       = fcnt_q;
    done_d       = 1'b0;
    hit_d        = hit_q;
    rdata_d      = rdata_q;
    dwe          = 1'b0;
    dwdata       = wdata_q;
    fill         = 1'b0;
    clr          = 1'b0;

    // A flush arriving mid-request is remembered and serviced once back in IDLE.
    if (bus.flush && state_q != IDLE && state_q != FLUSH) flush_pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.flush || flush_pend_q) begin
          state_d      = FLUSH;
          flush_pend_d = 1'b0;
          fcnt_d       = '0;
        end else if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          we_d    = bus.cpu_we;
          wdata_d = bus.cpu_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (we_q) begin
          whit_d  = hit;
          dwe     = hit;   // keep a resident copy coherent; misses never allocate
          state_d = MEM_WR;
        end else if (hit) begin
          done_d  = 1'b1;
          hit_d   = 1'b1;
          rdata_d = data_mem[idx];
          state_d = IDLE;
        end else begin
          state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        if (bus.mem_ack) begin
          fill    = 1'b1;
          dwe     = 1'b1;
          dwdata  = bus.mem_rdata;
          rdata_d = bus.mem_rdata;
          done_d  = 1'b1;
          hit_d   = 1'b0;
          state_d = IDLE;
        end
      end
      MEM_WR: begin
        if (bus.mem_ack) begin
          done_d  = 1'b1;
          hit_d   = whit_q;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        clr    = 1'b1;
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == {INDEX_W{1'b1}}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      whit_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      fcnt_q       <= '0;
      done_q       <= 1'b0;
      hit_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      whit_q       <= whit_d;
      flush_pend_q <= flush_pend_d;
      fcnt_q       <= fcnt_d;
      done_q       <= done_d;
      hit_q        <= hit_d;
      rdata_q      <= rdata_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       valid_q         <= '0;
    else if (clr)  valid_q[fcnt_q] <= 1'b0;
    else if (fill) valid_q[idx]    <= 1'b1;
  end

  // Tag/data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (dwe)  data_mem[idx] <= dwdata;
    if (fill) tag_mem[idx]  <= atag;
  end

  // Ready is gated by rst so every output reads 0 while reset is held.
  assign bus.cpu_ready = (state_q == IDLE) && !rst;
  assign bus.cpu_done  = done_q;
  assign bus.cpu_hit   = hit_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.mem_req   = (state_q == MEM_RD) || (state_q == MEM_WR);
  assign bus.mem_we    = (state_q == MEM_WR);
  assign bus.mem_addr  = {addr_q[ADDR_W-1:2], addr_q[1:0] & 2'b00};
  assign bus.mem_wdata = wdata_q;
endmodule
